// File: rtl/noun_phrase_classifier_if.sv
`default_nettype none
// ============================================================================
// noun_phrase_classifier_if : token stream in, phrase status out
// Revision : 1.0
// ============================================================================
interface noun_phrase_classifier_if #(
    parameter int CODE_W = 4,
    parameter int CNT_W  = 8
);
    logic              ready_i;
    logic              ok_i;
    logic [CODE_W-1:0] token_i;
    logic [2:0]        state_o;
    logic              fim_o;
    logic              err_o;
    logic [CNT_W-1:0]  token_cnt_o;
    logic [CNT_W-1:0]  phrase_len_o;
    logic [CNT_W-1:0]  phrase_cnt_o;

    modport master (
        output ready_i, ok_i, token_i,
        input  state_o, fim_o, err_o, token_cnt_o, phrase_len_o, phrase_cnt_o
    );

    modport slave (
        input  ready_i, ok_i, token_i,
        output state_o, fim_o, err_o, token_cnt_o, phrase_len_o, phrase_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/noun_phrase_classifier.sv
`default_nettype none
// ============================================================================
// noun_phrase_classifier : noun-phrase sequence FSM with length/timeout errors
// Revision : 1.0
// ============================================================================
module noun_phrase_classifier #(
    parameter int                CODE_W     = 4,
    parameter logic [CODE_W-1:0] CONCRETO   = 4'b0111,
    parameter logic [CODE_W-1:0] ABSTRATO   = 4'b1001,
    parameter logic [CODE_W-1:0] NOMEP      = 4'b1010,
    parameter logic [CODE_W-1:0] NOTA_INV   = 4'b1100,
    parameter int                MAX_TOKENS = 8,
    parameter int                TIMEOUT    = 16,
    parameter int                CNT_W      = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    noun_phrase_classifier_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CONC = 3'd1,
        S_ABST = 3'd2,
        S_PROP = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MAX_CNT  = CNT_W'(MAX_TOKENS);
    localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_FULL = {CNT_W{1'b1}};

    state_t           state_q;
    logic             ok_q;
    logic             fim_q;
    logic             err_q;
    logic [CNT_W-1:0] token_cnt_q;
    logic [CNT_W-1:0] phrase_len_q;
    logic [CNT_W-1:0] phrase_cnt_q;
    logic [CNT_W-1:0] timer_q;

    logic             accept;
    logic             is_conc;
    logic             is_abst;
    logic             is_prop;
    logic             is_nota;
    logic             code_valid;
    logic             at_limit;
    logic             active;
    logic             timer_expired;
    logic [CNT_W-1:0] token_cnt_d;
    logic [CNT_W-1:0] phrase_cnt_d;
    logic [CNT_W-1:0] timer_d;

    // Only the rising edge of the ok level counts, so a held strobe is one token.
    assign accept        = bus.ready_i & bus.ok_i & ~ok_q;
    assign is_conc       = (bus.token_i == CONCRETO);
    assign is_abst       = (bus.token_i == ABSTRATO);
    assign is_prop       = (bus.token_i == NOMEP);
    assign is_nota       = (bus.token_i == NOTA_INV);
    assign code_valid    = is_conc | is_abst | is_prop | is_nota;
    assign at_limit      = (token_cnt_q == C_MAX_CNT);
    assign active        = (state_q == S_CONC) | (state_q == S_ABST) | (state_q == S_PROP);
    assign token_cnt_d   = token_cnt_q + C_ONE;
    assign phrase_cnt_d  = (phrase_cnt_q == C_CNT_FULL) ? phrase_cnt_q : phrase_cnt_q + C_ONE;
    assign timer_d       = timer_q + C_ONE;
    assign timer_expired = (TIMEOUT != 0) && (timer_d == C_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ok_q         <= 1'b0;
            fim_q        <= 1'b0;
            err_q        <= 1'b0;
            token_cnt_q  <= '0;
            phrase_len_q <= '0;
            phrase_cnt_q <= '0;
            timer_q      <= '0;
        end else begin
            ok_q  <= bus.ok_i;
            fim_q <= 1'b0;
            err_q <= 1'b0;
            if (!bus.ready_i) begin
                state_q     <= S_IDLE;
                token_cnt_q <= '0;
                timer_q     <= '0;
            end else if (state_q == S_ERR) begin
                err_q <= 1'b1;
            end else if (accept) begin
                timer_q <= '0;
                if (!code_valid || (state_q != S_IDLE && at_limit)) begin
                    state_q <= S_ERR;
                    err_q   <= 1'b1;
                end else if (state_q == S_IDLE && is_nota) begin
                    // A stray terminator outside a phrase is dropped silently.
                    state_q <= S_IDLE;
                end else begin
                    token_cnt_q <= token_cnt_d;
                    case (state_q)
                        S_IDLE: begin
                            if (is_conc)      state_q <= S_CONC;
                            else if (is_abst) state_q <= S_ABST;
                            else              state_q <= S_PROP;
                        end
                        S_CONC: begin
                            if (is_abst)      state_q <= S_ABST;
                            else if (is_prop) state_q <= S_PROP;
                        end
                        S_ABST: begin
                            if (is_prop)      state_q <= S_PROP;
                        end
                        S_PROP: begin
                            if (is_nota) begin
                                state_q      <= S_IDLE;
                                token_cnt_q  <= '0;
                                phrase_len_q <= token_cnt_d;
                                phrase_cnt_q <= phrase_cnt_d;
                                fim_q        <= 1'b1;
                            end
                        end
                        default: state_q <= S_ERR;
                    endcase
                end
            end else if (active) begin
                timer_q <= timer_d;
                if (timer_expired) begin
                    state_q <= S_ERR;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.state_o      = state_q;
    assign bus.fim_o        = fim_q;
    assign bus.err_o        = err_q;
    assign bus.token_cnt_o  = token_cnt_q;
    assign bus.phrase_len_o = phrase_len_q;
    assign bus.phrase_cnt_o = phrase_cnt_q;
endmodule

`default_nettype wire
